// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch, waits WAIT_STATES cycles, then acks with the word.
// A load port writes the array while idle; loads arriving while busy are dropped and flagged.
module imem_responder #(
  parameter int          DEPTH       = 32,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_ack,
  output logic [31:0]              fetch_instr,
  output logic                     fetch_err,
  output logic                     busy,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     load_rej
);
  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_addr;
  logic [31:0] r_instr;
  logic        r_err;
  logic        r_load_rej;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]   w_rd_addr;
  logic [29:0]   w_idx;
  logic [AW-1:0] w_mem_idx;
  logic          w_err;
  logic [31:0]   w_word;
  logic          w_load_ok;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (fetch_req) begin
          if (WAIT_STATES == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = WS;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, before the address is latched.
  assign w_rd_addr = (r_state == S_IDLE) ? fetch_addr : r_addr;
  assign w_idx     = w_rd_addr[31:2];
  assign w_mem_idx = w_idx[AW-1:0];
  assign w_err     = (w_rd_addr[1:0] != 2'b00) || (w_idx >= 30'(DEPTH));
  assign w_load_ok = load_en && (r_state == S_IDLE);

  // A same-edge load to the word being read must win, since the read is defined to happen later.
  assign w_word = (w_load_ok && (load_addr == w_mem_idx)) ? load_data : r_mem[w_mem_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_instr    <= 32'd0;
      r_err      <= 1'b0;
      r_load_rej <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_load_rej <= load_en && (r_state != S_IDLE);
      if ((r_state == S_IDLE) && fetch_req) r_addr <= fetch_addr;
      if (w_next == S_RESP) begin
        r_instr <= w_err ? NOP_WORD : w_word;
        r_err   <= w_err;
      end
    end
  end

  // Program contents survive reset.
  always_ff @(posedge clk) begin
    if (w_load_ok) r_mem[load_addr] <= load_data;
  end

  assign fetch_ack   = (r_state == S_RESP);
  assign busy        = (r_state != S_IDLE);
  assign fetch_instr = r_instr;
  assign fetch_err   = r_err;
  assign load_rej    = r_load_rej;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one WAIT_STATES=1 instance plus 0- and 3-wait-state instances.
module tb_imem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = 5'd0;
  logic [31:0] load_data = 32'd0;
  logic        fetch_ack, fetch_err, busy, load_rej;
  logic [31:0] fetch_instr;

  logic        req0 = 1'b0, req3 = 1'b0;
  logic [31:0] fa_aux = 32'd0;
  logic        ack0, ack3, err0, err3, busy0, busy3, rej0, rej3;
  logic [31:0] instr0, instr3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(32), .WAIT_STATES(1), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr), .fetch_err(fetch_err), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_rej(load_rej));

  imem_responder #(.DEPTH(32), .WAIT_STATES(0), .NOP_WORD(32'h0)) dut_w0 (
    .clk(clk), .rst(rst), .fetch_req(req0), .fetch_addr(fa_aux),
    .fetch_ack(ack0), .fetch_instr(instr0), .fetch_err(err0), .busy(busy0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_rej(rej0));

  imem_responder #(.DEPTH(32), .WAIT_STATES(3), .NOP_WORD(32'h0)) dut_w3 (
    .clk(clk), .rst(rst), .fetch_req(req3), .fetch_addr(fa_aux),
    .fetch_ack(ack3), .fetch_instr(instr3), .fetch_err(err3), .busy(busy3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_rej(rej3));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Issues one fetch from IDLE; ack must be seen on the 2nd sample after acceptance (WAIT_STATES=1).
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e,
                          input string nm);
    int lat;
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    load_en    = 1'b0;
    fetch_addr = 32'hFFFF_FFF3;
    chk({nm, " busy_on"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (!fetch_ack && lat < 12) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, 32'd2);
    chk({nm, " instr"}, fetch_instr, exp_i);
    chk({nm, " err"}, {31'd0, fetch_err}, {31'd0, exp_e});
    tick();
    chk({nm, " busy_off"}, {30'd0, busy, fetch_ack}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int f0, f3, j;
    logic saw_ack;

    for (int i = 0; i < 17; i++) begin
      vt[i].addr  = 32'(i * 4);
      vt[i].instr = 32'h2008_0005 + 32'(i);
      vt[i].err   = 1'b0;
    end
    vt[17] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vt[18] = '{32'h0000_0080, 32'h0000_0000, 1'b1};
    vt[19] = '{32'h0000_0000, 32'h2008_0005, 1'b0};

    #1 rst = 1'b0;
    #1;
    chk("rst ack",   {31'd0, fetch_ack}, 32'd0);
    chk("rst instr", fetch_instr, 32'd0);
    chk("rst err",   {31'd0, fetch_err}, 32'd0);
    chk("rst busy",  {31'd0, busy}, 32'd0);
    chk("rst rej",   {31'd0, load_rej}, 32'd0);
    chk("rst aux",   {24'd0, ack0, ack3, busy0, busy3, rej0, rej3, err0, err3}, 32'd0);
    #2 rst = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) do_load(5'(i), 32'h2008_0005 + 32'(i));

    // Back-to-back fetches with fetch_req held high on the 0- and 3-wait-state instances.
    req0 = 1'b1;
    req3 = 1'b1;
    f0 = -1;
    f3 = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (f0 < 0 && ack0) f0 = c;
      if (f3 < 0 && ack3) f3 = c;
      if (f0 >= 0) begin
        j = c - f0;
        chk("w0 ack",  {31'd0, ack0},  {31'd0, (j % 2) == 0});
        chk("w0 busy", {31'd0, busy0}, {31'd0, (j % 2) != 1});
        if (ack0) chk("w0 instr", instr0, 32'h2008_0005);
      end
      if (f3 >= 0) begin
        j = c - f3;
        chk("w3 ack",  {31'd0, ack3},  {31'd0, (j % 5) == 0});
        chk("w3 busy", {31'd0, busy3}, {31'd0, (j % 5) != 1});
        if (ack3) chk("w3 instr", instr3, 32'h2008_0005);
      end
    end
    chk("w0 first ack", f0, 32'd0);
    chk("w3 first ack", f3, 32'd3);
    req0 = 1'b0;
    req3 = 1'b0;

    for (int i = 0; i < 20; i++) do_fetch(vt[i].addr, vt[i].instr, vt[i].err, $sformatf("vec%0d", i));

    // Load issued while the fetch is in WAIT must be dropped and flagged once.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0008;
    tick();
    fetch_req = 1'b0;
    load_en   = 1'b1;
    load_addr = 5'd2;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    chk("busyload rej",   {31'd0, load_rej}, 32'd1);
    chk("busyload ack",   {31'd0, fetch_ack}, 32'd1);
    chk("busyload instr", fetch_instr, 32'h2008_0007);
    tick();
    chk("busyload rej_off", {31'd0, load_rej}, 32'd0);
    do_fetch(32'h0000_0008, 32'h2008_0007, 1'b0, "old_word");

    load_en   = 1'b1;
    load_addr = 5'd3;
    load_data = 32'hCAFE_F00D;
    do_fetch(32'h0000_000C, 32'hCAFE_F00D, 1'b0, "same_edge");

    // Reset pulse while in WAIT abandons the fetch but keeps the array.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0004;
    tick();
    fetch_req = 1'b0;
    chk("midrst busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst outputs", {29'd0, fetch_ack, busy, fetch_err}, 32'd0);
    chk("midrst instr", fetch_instr, 32'd0);
    #2 rst = 1'b1;
    saw_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fetch_ack || busy) saw_ack = 1'b1;
    end
    chk("midrst no_ack", {31'd0, saw_ack}, 32'd0);
    do_fetch(32'h0000_0000, 32'h2008_0005, 1'b0, "retained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
